ram_scan_ctrl: RTL and testbench

RAM_SCAN_CTRL -- requirements
Module: ram_scan_ctrl

---
 rtl/ram_scan_ctrl.sv | 102 ++++++++++
 tb/tb_ram_scan_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_ctrl.sv
// Scans addresses 0..3 of a 2-bit RAM and packs the four data pairs into one byte.
// Optional RAM_SCAN_PARITY_EN adds word_par, the registered XOR of the word.
module ram_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_1,
    output logic       a_0,
    input  logic       o_1,
    input  logic       o_0,
    output logic       busy,
    output logic [7:0] word,
    output logic       word_valid,
    input  logic       word_ready
`ifdef RAM_SCAN_PARITY_EN
    ,
    output logic       word_par
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] word_q, word_d;
    logic       par_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 2'd0;
            settle_q <= 4'd0;
            word_q   <= 8'h00;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            settle_q <= settle_d;
            word_q   <= word_d;
            par_q    <= ^word_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        settle_d = settle_q;
        word_d   = word_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    addr_d   = 2'd0;
                    settle_d = SETTLE_RELOAD;
                    word_d   = 8'h00;
                end
            end
            SCAN: begin
                // settle_q==0 marks the last cycle this address is held
                if (settle_q == 4'd0) begin
                    word_d[{addr_q, 1'b0} +: 2] = {o_1, o_0};
                    if (addr_q == 2'd3) begin
                        state_d = VALID;
                        addr_d  = 2'd0;
                    end else begin
                        addr_d   = addr_q + 2'd1;
                        settle_d = SETTLE_RELOAD;
                    end
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            VALID: begin
                if (word_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign {a_1, a_0}  = (state_q == SCAN) ? addr_q : 2'b00;
    assign busy        = (state_q != IDLE);
    assign word_valid  = (state_q == VALID);
    assign word        = word_q;
`ifdef RAM_SCAN_PARITY_EN
    assign word_par    = par_q;
`else
    logic unused_par;
    assign unused_par  = par_q;
`endif

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Directed bench for ram_scan_ctrl with SETTLE_CYCLES=1 and SETTLE_CYCLES=3 instances.
module tb_ram_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       word_ready;
    logic [1:0] ram_mode;

    logic       start1, a1_1, a1_0, o1_1, o1_0, busy1, wv1;
    logic [7:0] word1;
    logic       start3, a3_1, a3_0, o3_1, o3_0, busy3, wv3;
    logic [7:0] word3;
`ifdef RAM_SCAN_PARITY_EN
    logic       par1, par3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // mode 0: o_1=a_1&a_0, o_0=~a_1&a_0; mode 1: o_0 forced 1; mode 2: o_0=1 only at address 0
    function automatic logic [1:0] ram(input logic [1:0] mode, input logic [1:0] a);
        case (mode)
            2'd0:    return {a[1] & a[0], ~a[1] & a[0]};
            2'd1:    return 2'b01;
            default: return {1'b0, (a == 2'd0)};
        endcase
    endfunction

    assign {o1_1, o1_0} = ram(ram_mode, {a1_1, a1_0});
    assign {o3_1, o3_0} = ram(ram_mode, {a3_1, a3_0});

    ram_scan_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_1(a1_1), .a_0(a1_0), .o_1(o1_1), .o_0(o1_0),
        .busy(busy1), .word(word1), .word_valid(wv1), .word_ready(word_ready)
`ifdef RAM_SCAN_PARITY_EN
        , .word_par(par1)
`endif
    );

    ram_scan_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a_1(a3_1), .a_0(a3_0), .o_1(o3_1), .o_0(o3_0),
        .busy(busy3), .word(word3), .word_valid(wv3), .word_ready(word_ready)
`ifdef RAM_SCAN_PARITY_EN
        , .word_par(par3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on dut1, walk the four addresses, then check the offered word.
    task automatic scan1(input logic [7:0] exp_word);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("s1_addr", {a1_1, a1_0}, i);
            chk("s1_wv_low", wv1, 1'b0);
            tick();
        end
        chk("s1_wv", wv1, 1'b1);
        chk("s1_word", word1, exp_word);
        chk("s1_addr_valid", {a1_1, a1_0}, 2'b00);
    endtask

    task automatic handshake1();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("hs_busy", busy1, 1'b0);
        chk("hs_wv", wv1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; word_ready = 1'b0; ram_mode = 2'd0;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("rst_busy", busy1, 1'b0);
        chk("rst_wv", wv1, 1'b0);
        chk("rst_word", word1, 8'h00);
        chk("rst_addr", {a1_1, a1_0}, 2'b00);
        rst_n = 1'b1;
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("idle_ready_busy", busy1, 1'b0);

        // Basic scan, SETTLE_CYCLES=1
        scan1(8'h84);
        chk("s1_busy_valid", busy1, 1'b1);
`ifdef RAM_SCAN_PARITY_EN
        chk("par_84", par1, 1'b0);
`endif
        handshake1();
        chk("word_hold", word1, 8'h84);
        tick();
        chk("word_hold2", word1, 8'h84);

        // SETTLE_CYCLES=3: each address held three cycles
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("s3_addr", {a3_1, a3_0}, i / 3);
            chk("s3_wv_low", wv3, 1'b0);
            tick();
        end
        chk("s3_wv", wv3, 1'b1);
        chk("s3_word", word3, 8'h84);
        // Consumer stalls for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_wv", wv3, 1'b1);
            chk("stall_word", word3, 8'h84);
        end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("s3_idle_busy", busy3, 1'b0);
        chk("s3_idle_wv", wv3, 1'b0);

        // start re-pulsed during scan and in the handshake cycle
        start1 = 1'b1;
        tick();
        chk("rs_addr0", {a1_1, a1_0}, 2'd0);
        tick();
        chk("rs_addr1", {a1_1, a1_0}, 2'd1);
        start1 = 1'b0;
        tick();
        chk("rs_addr2", {a1_1, a1_0}, 2'd2);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("rs_addr3", {a1_1, a1_0}, 2'd3);
        tick();
        chk("rs_wv", wv1, 1'b1);
        chk("rs_word", word1, 8'h84);
        start1 = 1'b1;
        handshake1();
        start1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_no_restart", busy1, 1'b0);
        end

        // Reset mid-scan at address 2
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        chk("ab_addr2", {a1_1, a1_0}, 2'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ab_busy", busy1, 1'b0);
        chk("ab_wv", wv1, 1'b0);
        chk("ab_word", word1, 8'h00);
        chk("ab_addr", {a1_1, a1_0}, 2'b00);
        tick();
        chk("ab_idle", busy1, 1'b0);
        scan1(8'h84);
        handshake1();

        // Alternate RAM contents
        ram_mode = 2'd1;
        scan1(8'h55);
`ifdef RAM_SCAN_PARITY_EN
        chk("par_55", par1, 1'b0);
`endif
        handshake1();
        ram_mode = 2'd2;
        scan1(8'h01);
`ifdef RAM_SCAN_PARITY_EN
        chk("par_01", par1, 1'b1);
`endif
        handshake1();
        chk("final_word", word1, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
